div_ctrl: RTL and testbench

EX-stage controller that sits directly upstream of the iterative divider. Decodes DIV/DIVU requests from the EX stage, latches operands and drives the divider's start/annul handshake. Stalls the pipeline while the quotient is computed, then presents the HI (remainder) / LO (quotient) write to the HI/LO register file when the instruction leaves EX. Also cleanly aborts an in-flight division on a pipeline flush.

---
 rtl/div_ctrl.sv | 135 +++++++++++++
 tb/tb_div_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// EX-stage controller for the iterative divider: latches DIV/DIVU operands, runs the
// start/annul handshake, stalls EX while busy and presents the HI/LO write on exit.
module div_ctrl #(
    parameter int ABORT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic        ex_stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = (ABORT_CYCLES < 2) ? 1 : $clog2(ABORT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e        state_q;
    logic          start_q;
    logic          annul_q;
    logic          signed_q;
    logic [31:0]   op1_q;
    logic [31:0]   op2_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [CW-1:0] abort_cnt_q;

    logic          new_req;

    assign new_req = div_req_i & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            annul_q     <= 1'b0;
            signed_q    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            abort_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (new_req) begin
                        op1_q    <= op1_i;
                        op2_q    <= op2_i;
                        signed_q <= div_signed_i;
                        start_q  <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    // A flush discards a result arriving in the same cycle.
                    if (flush_i) begin
                        start_q     <= 1'b0;
                        annul_q     <= 1'b1;
                        abort_cnt_q <= CW'(ABORT_CYCLES - 1);
                        state_q     <= ABORT;
                    end else if (div_ready_i) begin
                        hi_q    <= div_result_i[63:32];
                        lo_q    <= div_result_i[31:0];
                        start_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (flush_i || !ex_stall_i) begin
                        state_q <= IDLE;
                    end
                end
                ABORT: begin
                    // Annul stays high long enough for the divider to reach its free state.
                    if (abort_cnt_q == '0) begin
                        annul_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        abort_cnt_q <= abort_cnt_q - 1'b1;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    annul_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall and write strobe are combinational so EX reacts in the same cycle;
    // they are masked by reset so every output reads 0 while rst is low.
    always_comb begin
        stallreq_o = 1'b0;
        hilo_we_o  = 1'b0;
        case (state_q)
            IDLE:    stallreq_o = new_req;
            BUSY:    stallreq_o = 1'b1;
            DONE:    hilo_we_o  = ~flush_i & ~ex_stall_i;
            ABORT:   stallreq_o = new_req;
            default: stallreq_o = 1'b0;
        endcase
        if (!rst) begin
            stallreq_o = 1'b0;
            hilo_we_o  = 1'b0;
        end
    end

    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider plus a per-transaction timeline model of the
// expected outputs, compared every cycle on the falling edge.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_req_i = 1'b0;
    logic        div_signed_i = 1'b0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        flush_i = 1'b0;
    logic        ex_stall_i = 1'b0;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic        stallreq_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl #(.ABORT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .div_req_i(div_req_i), .div_signed_i(div_signed_i),
        .op1_i(op1_i), .op2_i(op2_i),
        .flush_i(flush_i), .ex_stall_i(ex_stall_i),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Behavioural divider: ready after 35 (or 3 for /0) sampled start cycles, held while start stays.
    logic [5:0] dcnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           dcnt <= '0;
        else if (div_start_o && !div_annul_o) dcnt <= (dcnt == 6'd63) ? dcnt : dcnt + 6'd1;
        else                                dcnt <= '0;
    end
    assign div_ready_i  = div_start_o && !div_annul_o &&
                          (dcnt >= ((div_op2_o == 32'd0) ? 6'd3 : 6'd35));
    assign div_result_i = div_ready_i ? ref_div(div_op1_o, div_op2_o, div_signed_o)
                                      : 64'hA5A5_5A5A_DEAD_BEEF;

    logic        e_start = 0, e_annul = 0, e_stall = 0, e_we = 0, e_sgn = 0;
    logic [31:0] e_hi = 0, e_lo = 0, e_op1 = 0, e_op2 = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("start", 64'(div_start_o), 64'(e_start));
        chk("annul", 64'(div_annul_o), 64'(e_annul));
        chk("stallreq", 64'(stallreq_o), 64'(e_stall));
        chk("hilo_we", 64'(hilo_we_o), 64'(e_we));
        chk("hi", 64'(hi_o), 64'(e_hi));
        chk("lo", 64'(lo_o), 64'(e_lo));
        chk("ops", {div_op1_o, div_op2_o}, {e_op1, e_op2});
        chk("signed", 64'(div_signed_o), 64'(e_sgn));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic st, input logic an, input logic sr, input logic we);
        e_start = st; e_annul = an; e_stall = sr; e_we = we;
    endtask

    // flush_at: 0 none, 1..L in BUSY, >L in DONE. rst_at: cycle in BUSY to pulse reset.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int hold, input int flush_at, input bit req_in_abort,
                          input int rst_at);
        int L;
        logic [63:0] res;
        L   = (b == 32'd0) ? 4 : 36;
        res = ref_div(a, b, s);
        div_req_i = 1; op1_i = a; op2_i = b; div_signed_i = s;
        flush_i = 0; ex_stall_i = 0;
        set_exp(0, 0, 1, 0);
        cyc();
        for (int k = 1; k <= L; k++) begin
            e_op1 = a; e_op2 = b; e_sgn = s;
            op1_i = $urandom; op2_i = $urandom;
            if (k == rst_at) begin
                rst = 0;
                e_op1 = 0; e_op2 = 0; e_sgn = 0; e_hi = 0; e_lo = 0;
                set_exp(0, 0, 0, 0);
                cyc();
                rst = 1; div_req_i = 0;
                cyc();
                return;
            end
            flush_i = (k == flush_at);
            set_exp(1, 0, 1, 0);
            cyc();
            if (k == flush_at) begin
                flush_i = 0;
                for (int i = 0; i < 2; i++) begin
                    div_req_i = req_in_abort;
                    set_exp(0, 1, req_in_abort, 0);
                    cyc();
                end
                return;
            end
        end
        e_hi = res[63:32]; e_lo = res[31:0];
        for (int d = 0; d <= hold; d++) begin
            if (L + 1 + d == flush_at) begin
                flush_i = 1; ex_stall_i = (d < hold);
                set_exp(0, 0, 0, 0);
                cyc();
                flush_i = 0;
                break;
            end
            ex_stall_i = (d < hold);
            set_exp(0, 0, 0, (d == hold));
            cyc();
        end
        div_req_i = 0; ex_stall_i = 0;
        set_exp(0, 0, 0, 0);
        cyc();
    endtask

    initial begin
        int L, fmode, fat;
        logic [31:0] ra, rb;
        rst = 0;
        set_exp(0, 0, 0, 0);
        cyc();
        cyc();
        rst = 1;
        cyc();

        do_div(32'd100, 32'd7, 0, 0, 0, 0, 0);
        chk("lit_divu_hi", 64'(hi_o), 64'h2);
        chk("lit_divu_lo", 64'(lo_o), 64'hE);
        do_div(32'hFFFF_FFF9, 32'd2, 1, 0, 0, 0, 0);
        chk("lit_div_neg", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        chk("lit_div_ovf", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        do_div(32'd5, 32'd0, 0, 0, 0, 0, 0);
        chk("lit_div0", {hi_o, lo_o}, 64'h0);
        do_div(32'd100, 32'd7, 0, 4, 0, 0, 0);
        chk("lit_hold", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
        do_div(32'd1000, 32'd13, 0, 0, 10, 0, 0);
        do_div(32'd9, 32'd3, 0, 0, 0, 0, 0);
        chk("lit_after_flush", {hi_o, lo_o}, 64'h0000_0000_0000_0003);
        do_div(32'd12345, 32'd17, 1, 0, 0, 0, 20);
        chk("lit_after_rst", {hi_o, lo_o}, 64'h0);
        do_div(32'd100, 32'd7, 0, 0, 0, 0, 0);
        chk("lit_post_rst", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
        do_div(32'd77, 32'd5, 0, 0, 36, 1, 0);
        do_div(32'd77, 32'd5, 0, 1, 0, 0, 0);
        chk("lit_flush_ready", {hi_o, lo_o}, 64'h0000_0002_0000_000F);

        for (int it = 0; it < 40; it++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            L = (rb == 32'd0) ? 4 : 36;
            fmode = $urandom_range(0, 7);
            fat = (fmode < 2) ? $urandom_range(1, L) :
                  (fmode == 2) ? L + 1 + $urandom_range(0, 2) : 0;
            do_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), fat,
                   1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
